// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result bundle for the bit-serial subtractor.
//   start, a, b, bin : request and operands, driven by the requester (master)
//   busy, done       : status, driven by the subtractor (slave)
//   d, bout          : registered difference and final borrow-out
// WIDTH must match the WIDTH of the serial_subtractor bound to this interface.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial full subtractor computing d = a - b - bin,
// one bit per clock, LSB first, through a single full-subtractor cell and a
// borrow flop. An accepted start captures the operands; WIDTH cycles later
// done pulses for one cycle and d/bout hold the result until the next
// completion.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : serial_subtractor_if slave modport (start/a/b/bin in,
//         busy/done/d/bout out, all outputs registered)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Difference bit of one full-subtractor step.
  function automatic logic fs_diff(input logic x, input logic y, input logic br);
    return x ^ y ^ br;
  endfunction

  // Borrow out of one full-subtractor step: borrow when x < y, or when the
  // bits are equal and a borrow is already pending.
  function automatic logic fs_borrow(input logic x, input logic y, input logic br);
    return (~x & y) | (~(x ^ y) & br);
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] ra_r, ra_s;
  logic [WIDTH-1:0] rb_r, rb_s;
  logic             br_r, br_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] rd_r, rd_s;
  logic [WIDTH-1:0] d_r, d_s;
  logic             bout_r, bout_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             x_s;
  logic             bnext_s;

  // Next-state and datapath: one subtractor step per RUN cycle.
  always_comb begin
    state_s = state_r;
    ra_s    = ra_r;
    rb_s    = rb_r;
    br_s    = br_r;
    cnt_s   = cnt_r;
    rd_s    = rd_r;
    d_s     = d_r;
    bout_s  = bout_r;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    x_s     = fs_diff(ra_r[0], rb_r[0], br_r);
    bnext_s = fs_borrow(ra_r[0], rb_r[0], br_r);

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          ra_s    = bus.a;
          rb_s    = bus.b;
          br_s    = bus.bin;
          cnt_s   = '0;
          state_s = RUN;
          busy_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        ra_s  = {1'b0, ra_r[WIDTH-1:1]};
        rb_s  = {1'b0, rb_r[WIDTH-1:1]};
        br_s  = bnext_s;
        rd_s  = {x_s, rd_r[WIDTH-1:1]};
        cnt_s = cnt_r + CW'(1);
        if (cnt_r == CNT_LAST) begin
          // Last bit: publish the fully shifted result, not rd_r.
          d_s     = rd_s;
          bout_s  = bnext_s;
          done_s  = 1'b1;
          state_s = DONE;
        end else begin
          busy_s  = 1'b1;
          state_s = RUN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_r   <= '0;
      rb_r   <= '0;
      br_r   <= 1'b0;
      cnt_r  <= '0;
      rd_r   <= '0;
      d_r    <= '0;
      bout_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      ra_r   <= ra_s;
      rb_r   <= rb_s;
      br_r   <= br_s;
      cnt_r  <= cnt_s;
      rd_r   <= rd_s;
      d_r    <= d_s;
      bout_r <= bout_s;
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.d    = d_r;
  assign bus.bout = bout_r;

endmodule
